// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort detection, zero deletion, byte assembly.
// Rx is sampled one bit per Clk. The 8-bit pattern register doubles as the
// data delay line, so a flag or abort is always recognised before its bits
// reach the data path. One extra retiming stage (bit_q) feeds the data path.
// The skip counter then discards the 8 pattern bits as they drain out.
module hdlc_rx_deframer #(
  parameter int MAX_BYTES = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_AbortSignal,
  output logic       Rx_ValidFrame,
  output logic [7:0] Rx_Data,
  output logic       Rx_WrBuff,
  output logic       Rx_EoF,
  output logic       Rx_FrameError,
  output logic       Rx_Overflow
);

  localparam int         BCW   = $clog2(MAX_BYTES + 1) + 1;
  localparam logic [7:0] FLAG  = 8'h7E;  // 0,1,1,1,1,1,1,0 (oldest in bit 0)
  localparam logic [7:0] ABORT = 8'hFE;  // 0 then seven 1s (oldest in bit 0)

  typedef enum logic {IDLE, FRAME} state_t;

  state_t           state;
  logic [7:0]       pat;       // newest bit enters at bit 7
  logic             bit_q;     // candidate data bit, sampled 9 cycles earlier
  logic [2:0]       skip;      // pattern bits still draining out of the delay line
  logic [2:0]       ones;      // consecutive consumed 1s
  logic [2:0]       bit_cnt;   // consumed data bits mod 8
  logic             any_bit;   // at least one data bit consumed since the flag
  logic [BCW-1:0]   byte_cnt;
  logic [7:0]       shreg;
  logic [7:0]       nxt_byte;

  assign nxt_byte      = {bit_q, shreg[7:1]};
  assign Rx_ValidFrame = (state == FRAME);

  // Pattern register / delay line and registered flag/abort detection
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pat            <= '0;
      bit_q          <= 1'b0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
    end else begin
      pat            <= {Rx, pat[7:1]};
      bit_q          <= pat[0];
      Rx_FlagDetect  <= (pat == FLAG);
      Rx_AbortDetect <= (pat == ABORT);
    end
  end

  // Frame FSM, zero deletion and byte assembly with registered strobes
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state          <= IDLE;
      skip           <= '0;
      ones           <= '0;
      bit_cnt        <= '0;
      any_bit        <= 1'b0;
      byte_cnt       <= '0;
      shreg          <= '0;
      Rx_Data        <= '0;
      Rx_WrBuff      <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
      Rx_Overflow    <= 1'b0;
      Rx_AbortSignal <= 1'b0;
    end else begin
      Rx_WrBuff      <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
      Rx_Overflow    <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      if (Rx_AbortDetect) begin
        // abort wins over a (pattern-impossible) simultaneous flag
        skip     <= 3'd7;
        ones     <= '0;
        bit_cnt  <= '0;
        any_bit  <= 1'b0;
        byte_cnt <= '0;
        if (state == FRAME) begin
          Rx_AbortSignal <= 1'b1;
          state          <= IDLE;
        end
      end else if (Rx_FlagDetect) begin
        skip     <= 3'd7;
        ones     <= '0;
        bit_cnt  <= '0;
        any_bit  <= 1'b0;
        byte_cnt <= '0;
        if (state == IDLE) begin
          state <= FRAME;
        end else if (any_bit) begin
          // closing flag: frame ends, the next flag opens a new one
          Rx_EoF        <= 1'b1;
          Rx_FrameError <= (bit_cnt != 3'd0) || (byte_cnt == '0);
          state         <= IDLE;
        end
      end else if (skip != 3'd0) begin
        skip <= skip - 3'd1;
      end else if (state == FRAME) begin
        if (ones == 3'd5 && !bit_q) begin
          // stuffed zero: dropped, not counted as data
          ones <= '0;
        end else begin
          ones    <= bit_q ? ((ones == 3'd7) ? ones : ones + 3'd1) : 3'd0;
          any_bit <= 1'b1;
          shreg   <= nxt_byte;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_cnt == BCW'(MAX_BYTES)) begin
              Rx_Overflow <= 1'b1;
              state       <= IDLE;
              byte_cnt    <= '0;
              any_bit     <= 1'b0;
              ones        <= '0;
            end else begin
              Rx_Data   <= nxt_byte;
              Rx_WrBuff <= 1'b1;
              byte_cnt  <= byte_cnt + BCW'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed bench for hdlc_rx_deframer. Outputs are logged per cycle at the
// falling edge; each scenario then checks event counts and exact cycles
// against hand-derived offsets from T (cycle the last pattern bit is on Rx).
module tb_hdlc_rx_deframer;

  localparam int NC = 2048;

  logic       Clk, Rst, Rx;
  logic       flag, abrt, asig, vld, wr, eof, ferr, ovf;
  logic [7:0] data;
  logic       flag4, abrt4, asig4, vld4, wr4, eof4, ferr4, ovf4;
  logic [7:0] data4;

  hdlc_rx_deframer dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx),
    .Rx_FlagDetect(flag), .Rx_AbortDetect(abrt), .Rx_AbortSignal(asig),
    .Rx_ValidFrame(vld), .Rx_Data(data), .Rx_WrBuff(wr), .Rx_EoF(eof),
    .Rx_FrameError(ferr), .Rx_Overflow(ovf)
  );

  hdlc_rx_deframer #(.MAX_BYTES(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .Rx(Rx),
    .Rx_FlagDetect(flag4), .Rx_AbortDetect(abrt4), .Rx_AbortSignal(asig4),
    .Rx_ValidFrame(vld4), .Rx_Data(data4), .Rx_WrBuff(wr4), .Rx_EoF(eof4),
    .Rx_FrameError(ferr4), .Rx_Overflow(ovf4)
  );

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int last_t;

  logic [NC-1:0] h_flag, h_abrt, h_asig, h_vld, h_wr, h_eof, h_ferr;
  logic [NC-1:0] h_vld4, h_wr4, h_eof4, h_ovf4;
  logic [7:0]    h_d  [NC];
  logic [7:0]    h_d4 [NC];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // per-cycle output log, sampled mid-cycle
  always @(negedge Clk) begin
    if (cyc < NC) begin
      h_flag[cyc] <= flag;  h_abrt[cyc] <= abrt;  h_asig[cyc] <= asig;
      h_vld[cyc]  <= vld;   h_wr[cyc]   <= wr;    h_eof[cyc]  <= eof;
      h_ferr[cyc] <= ferr;  h_d[cyc]    <= data;
      h_vld4[cyc] <= vld4;  h_wr4[cyc]  <= wr4;   h_eof4[cyc] <= eof4;
      h_ovf4[cyc] <= ovf4;  h_d4[cyc]   <= data4;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int cnt(input logic [NC-1:0] v, input int a, input int b);
    int n;
    n = 0;
    for (int i = a; i <= b; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge Clk);
    Rx = b;
    last_t = cyc;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic idle0(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic do_reset;
    @(negedge Clk);
    Rx  = 1'b0;
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    int t1, tm, tc, t4, t5, ta;
    Rx  = 1'b0;
    Rst = 1'b0;
    #1 Rst = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_vld",  int'(vld),  0);
    chk("rst_data", int'(data), 0);
    chk("rst_puls", int'(flag | abrt | asig | wr | eof | ferr | ovf), 0);
    chk("rst_vld4", int'(vld4), 0);
    Rst = 1'b0;

    // flag, 0x5A, flag
    do_reset;
    send_byte(8'h7E); t1 = last_t;
    send_byte(8'h5A); tm = last_t;
    send_byte(8'h7E); tc = last_t;
    idle0(24);
    chk("s1_flag_t2",  int'(h_flag[t1+2]), 1);
    chk("s1_flag_t1",  int'(h_flag[t1+1]), 0);
    chk("s1_flag_n",   cnt(h_flag, t1, tc+15), 2);
    chk("s1_vld_t2",   int'(h_vld[t1+2]), 0);
    chk("s1_vld_t3",   int'(h_vld[t1+3]), 1);
    chk("s1_wr_n",     cnt(h_wr, t1, tc+15), 1);
    chk("s1_wr_t",     int'(h_wr[tm+10]), 1);
    chk("s1_data",     int'(h_d[tm+10]), 8'h5A);
    chk("s1_eof",      int'(h_eof[tc+3]), 1);
    chk("s1_ferr_n",   cnt(h_ferr, t1, tc+15), 0);
    chk("s1_vld_end",  int'(h_vld[tc+3]), 0);
    chk("s1_hold",     int'(h_d[tc+12]), 8'h5A);

    // 0xFF stuffed: 11111 0 111
    do_reset;
    send_byte(8'h7E); t1 = last_t;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    tm = last_t;
    send_byte(8'h7E); tc = last_t;
    idle0(24);
    chk("s2_wr_n",    cnt(h_wr, t1, tc+15), 1);
    chk("s2_wr_t",    int'(h_wr[tm+10]), 1);
    chk("s2_data",    int'(h_d[tm+10]), 8'hFF);
    chk("s2_abrt_n",  cnt(h_abrt, t1, tc+15), 0);
    chk("s2_eof",     int'(h_eof[tc+3]), 1);
    chk("s2_ferr_n",  cnt(h_ferr, t1, tc+15), 0);

    // two bytes then abort
    do_reset;
    send_byte(8'h7E); t1 = last_t;
    send_byte(8'h12);
    send_byte(8'h34); tm = last_t;
    send_bit(1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    ta = last_t;
    idle0(24);
    chk("s3_abrt_t2", int'(h_abrt[ta+2]), 1);
    chk("s3_abrt_n",  cnt(h_abrt, t1, ta+15), 1);
    chk("s3_asig_t3", int'(h_asig[ta+3]), 1);
    chk("s3_asig_n",  cnt(h_asig, t1, ta+15), 1);
    chk("s3_vld_t2",  int'(h_vld[ta+2]), 1);
    chk("s3_vld_t3",  int'(h_vld[ta+3]), 0);
    chk("s3_eof_n",   cnt(h_eof, t1, ta+15), 0);
    chk("s3_wr_n",    cnt(h_wr, t1, ta+15), 2);
    chk("s3_data",    int'(h_d[tm+10]), 8'h34);

    // 20 ones while idle
    do_reset;
    send_bit(1'b0); t1 = last_t;
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b1);
      if (i == 6) ta = last_t;
    end
    tc = last_t;
    idle0(16);
    chk("s4_abrt_n",  cnt(h_abrt, t1, tc+12), 1);
    chk("s4_abrt_t",  int'(h_abrt[ta+2]), 1);
    chk("s4_asig_n",  cnt(h_asig, t1, tc+12), 0);
    chk("s4_vld_n",   cnt(h_vld, t1, tc+12), 0);

    // flag, 12 data bits, flag
    do_reset;
    send_byte(8'h7E); t1 = last_t;
    send_byte(8'hA5); tm = last_t;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    send_byte(8'h7E); tc = last_t;
    idle0(24);
    chk("s5_wr_n",    cnt(h_wr, t1, tc+15), 1);
    chk("s5_data",    int'(h_d[tm+10]), 8'hA5);
    chk("s5_eof",     int'(h_eof[tc+3]), 1);
    chk("s5_ferr",    int'(h_ferr[tc+3]), 1);
    chk("s5_ferr_n",  cnt(h_ferr, t1, tc+15), 1);

    // MAX_BYTES=4 with 5 bytes
    do_reset;
    send_byte(8'h7E); t1 = last_t;
    t4 = 0; t5 = 0;
    for (int b = 1; b <= 5; b++) begin
      send_byte(8'(b));
      if (b == 4) t4 = last_t;
      if (b == 5) t5 = last_t;
    end
    send_byte(8'h7E); tc = last_t;
    idle0(20);
    chk("s6_wr_n",    cnt(h_wr4, t1, tc+12), 4);
    chk("s6_data4",   int'(h_d4[t4+10]), 8'h04);
    chk("s6_ovf_t",   int'(h_ovf4[t5+10]), 1);
    chk("s6_ovf_n",   cnt(h_ovf4, t1, tc+12), 1);
    chk("s6_vld_ovf", int'(h_vld4[t5+10]), 0);
    chk("s6_vld_pre", int'(h_vld4[t5+9]), 1);
    chk("s6_eof_n",   cnt(h_eof4, t1, tc+12), 0);
    chk("s6_reopen",  int'(h_vld4[tc+3]), 1);
    chk("s6_hold",    int'(h_d4[tc+6]), 8'h04);

    // reset mid-frame discards the partial byte
    do_reset;
    send_byte(8'h7E); t1 = last_t;
    send_byte(8'h12); tm = last_t;
    do_reset;
    idle0(30);
    chk("s7_vld_pre", int'(h_vld[tm]), 1);
    chk("s7_wr_n",    cnt(h_wr, t1, tm+28), 0);
    chk("s7_vld_n",   cnt(h_vld, tm+3, tm+28), 0);
    chk("s7_data",    int'(h_d[tm+20]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
